// File: rtl/sys_array_result_drain_pkg.sv
// sys_array_result_drain_pkg: shared widths, element count, state encoding and ReLU helper
package sys_array_result_drain_pkg;
    localparam int DW = 8;
    localparam int N_ELEM = 9;
    localparam int IDX_LAST = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;
    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x, input logic en);
        return (en && x[DW-1]) ? '0 : x;
    endfunction
endpackage

// File: rtl/sys_array_result_drain_if.sv
// sys_array_result_drain_if: array request/result bus and row-major result stream
interface sys_array_result_drain_if;
    import sys_array_result_drain_pkg::*;
    logic go, relu_en, arr_done, arr_start;
    logic [DW-1:0] c00, c01, c02, c10, c11, c12, c20, c21, c22;
    logic [DW-1:0] out_data;
    logic [3:0] out_idx, neg_count;
    logic out_valid, out_last, out_ready, busy, done_pulse, timeout_err;
    modport master (
        input go, relu_en, arr_done, c00, c01, c02, c10, c11, c12, c20, c21, c22, out_ready,
        output arr_start, out_data, out_idx, out_valid, out_last, busy, done_pulse, neg_count, timeout_err
    );
    modport slave (
        output go, relu_en, arr_done, c00, c01, c02, c10, c11, c12, c20, c21, c22, out_ready,
        input arr_start, out_data, out_idx, out_valid, out_last, busy, done_pulse, neg_count, timeout_err
    );
endinterface

// File: rtl/sys_array_result_drain.sv
// sys_array_result_drain: requests one array multiply, captures on done rise, streams nine results
module sys_array_result_drain
    import sys_array_result_drain_pkg::*;
#(
    parameter int TIMEOUT = 16383
) (
    input logic clk,
    input logic rst,
    sys_array_result_drain_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic arr_done_q, rise, hs, last, timeout_hit, done_pulse, timeout_err;
    logic [3:0] idx, neg, neg_count;
    logic [DW-1:0] cap [N_ELEM];
    logic [DW-1:0] c_in [N_ELEM];
    assign rise = bus.arr_done & ~arr_done_q;
    assign hs = (state == DRAIN) & bus.out_ready;
    assign last = idx == 4'(IDX_LAST);
    assign timeout_hit = cnt == CW'(TIMEOUT - 1);
    assign bus.arr_start = state == REQ;
    assign bus.out_valid = state == DRAIN;
    assign bus.busy = state != IDLE;
    assign bus.out_last = (state == DRAIN) & last;
    assign bus.out_data = cap[idx];
    assign bus.out_idx = idx;
    assign bus.done_pulse = done_pulse;
    assign bus.neg_count = neg_count;
    assign bus.timeout_err = timeout_err;
    // Row-major view of the array results and their negative count
    always_comb begin
        c_in = '{bus.c00, bus.c01, bus.c02, bus.c10, bus.c11, bus.c12, bus.c20, bus.c21, bus.c22};
        neg = '0;
        for (int i = 0; i < N_ELEM; i++) neg = neg + 4'(c_in[i][DW-1]);
    end
    // Next state: a done rise beats a same-cycle timeout
    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.go) state_nx = REQ;
        if (state == REQ) state_nx = rise ? DRAIN : timeout_hit ? IDLE : REQ;
        if (hs && last) state_nx = IDLE;
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Request timer, result capture, drain index and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_done_q <= 1'b0;
            cnt <= '0;
            idx <= '0;
            neg_count <= '0;
            done_pulse <= 1'b0;
            timeout_err <= 1'b0;
            cap <= '{default: '0};
        end else begin
            arr_done_q <= bus.arr_done;
            done_pulse <= hs & last;
            if (state == IDLE && bus.go) begin
                cnt <= '0;
                timeout_err <= 1'b0;
            end
            if (state == REQ) begin
                cnt <= cnt + 1'b1;
                if (rise) begin
                    for (int i = 0; i < N_ELEM; i++) cap[i] <= relu(c_in[i], bus.relu_en);
                    neg_count <= neg;
                    idx <= '0;
                end else if (timeout_hit) begin
                    timeout_err <= 1'b1;
                end
            end
            if (hs) idx <= last ? '0 : idx + 4'd1;
        end
    end
endmodule
